// File: rtl/wimax_deinterleaver.sv
// WiMAX receive-side block deinterleaver: ping-pong bit banks, valid/ready on both sides.
// Optional feature macro DEINT_BLOCK_LAST_EN adds in_last, out_last and err_short.
module wimax_deinterleaver #(
   parameter int Ncbps = 192,
   parameter int Ncpc  = 2,
   parameter int d     = 16
) (
   input  logic clock_100,
   input  logic reset,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_data,
`ifdef DEINT_BLOCK_LAST_EN
   input  logic in_last,
   output logic out_last,
   output logic err_short,
`endif
   output logic out_valid,
   input  logic out_ready,
   output logic out_data
);

   localparam int unsigned   S    = (Ncpc / 2 > 1) ? Ncpc / 2 : 1;
   localparam int unsigned   AW   = $clog2(Ncbps);
   localparam logic [AW-1:0] LAST = AW'(Ncbps - 1);

   // Received index j -> original (deinterleaved) index k; 32-bit intermediates avoid truncation.
   function automatic logic [AW-1:0] deint_addr(input logic [AW-1:0] j);
      int unsigned jj, m, k;
      jj = 32'(j);
      m  = S * (jj / S) + ((jj + (d * jj) / Ncbps) % S);
      k  = d * m - (Ncbps - 1) * ((d * m) / Ncbps);
      return k[AW-1:0];
   endfunction

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

   bank_state_e      state_q [2];
   bank_state_e      state_d [2];
   logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic             out_valid_q, out_valid_d;
   logic             out_data_q, out_data_d;
   logic [Ncbps-1:0] mem_q [2];
   logic [AW-1:0]    wr_addr;
   logic             wr_fire, wr_end, rd_load, rd_end, rd_bit;

   assign in_ready  = (state_q[wr_bank_q] == EMPTY);
   assign wr_fire   = in_valid && in_ready;
   assign wr_addr   = deint_addr(wr_cnt_q);
   assign rd_load   = (!out_valid_q || out_ready) && (state_q[rd_bank_q] == FULL);
   assign rd_end    = rd_load && (rd_cnt_q == LAST);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef DEINT_BLOCK_LAST_EN
   logic [Ncbps-1:0] wmask_q [2];
   logic             out_last_q, err_short_q;

   // Positions never written in a short block must read back as 0.
   assign wr_end    = wr_fire && ((wr_cnt_q == LAST) || in_last);
   assign rd_bit    = mem_q[rd_bank_q][rd_cnt_q] & wmask_q[rd_bank_q][rd_cnt_q];
   assign out_last  = out_last_q;
   assign err_short = err_short_q;

   always_ff @(posedge clock_100) begin
      if (!reset) begin
         wmask_q[0]  <= '0;
         wmask_q[1]  <= '0;
         out_last_q  <= 1'b0;
         err_short_q <= 1'b0;
      end else begin
         if (rd_end)
            wmask_q[rd_bank_q] <= '0;
         if (wr_fire)
            wmask_q[wr_bank_q][wr_addr] <= 1'b1;
         if (rd_load)
            out_last_q <= (rd_cnt_q == LAST);
         else if (out_ready)
            out_last_q <= 1'b0;
         if (wr_fire && in_last && (wr_cnt_q != LAST))
            err_short_q <= 1'b1;
      end
   end
`else
   assign wr_end = wr_fire && (wr_cnt_q == LAST);
   assign rd_bit = mem_q[rd_bank_q][rd_cnt_q];
`endif

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (wr_fire)
         wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_end) begin
         state_d[wr_bank_q] = FULL;
         wr_bank_d          = ~wr_bank_q;
         wr_cnt_d           = '0;
      end

      if (rd_load) begin
         rd_cnt_d    = rd_cnt_q + 1'b1;
         out_valid_d = 1'b1;
         out_data_d  = rd_bit;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      // Write and read always target different banks, so both updates can land together.
      if (rd_end) begin
         state_d[rd_bank_q] = EMPTY;
         rd_bank_d          = ~rd_bank_q;
         rd_cnt_d           = '0;
      end
   end

   always_ff @(posedge clock_100) begin
      if (!reset) begin
         state_q[0]  <= EMPTY;
         state_q[1]  <= EMPTY;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clock_100) begin
      if (wr_fire)
         mem_q[wr_bank_q][wr_addr] <= in_data;
   end

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Bench for wimax_deinterleaver: instance 0 is Ncbps=192/Ncpc=2, instance 1 is Ncbps=384/Ncpc=4.
module tb_wimax_deinterleaver;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] in_valid, in_ready, in_data, out_valid, out_ready, out_data;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic orig  [8192];
   logic txbuf [8192];
   logic cap   [2][8192];
   int   capn  [2];
   bit   send_done;
   int   g, n, ones, pos;

   typedef struct {
      int inst;
      int j;
      int exp_idx;
   } vec_t;
   vec_t tbl [7];

   always #5 clk = ~clk;

`ifdef DEINT_BLOCK_LAST_EN
   logic [1:0] out_last_w, err_short_w;
`endif

   wimax_deinterleaver #(.Ncbps(192), .Ncpc(2), .d(16)) dut_a (
      .clock_100 (clk),
      .reset     (reset),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0]),
`ifdef DEINT_BLOCK_LAST_EN
      .in_last   (1'b0),
      .out_last  (out_last_w[0]),
      .err_short (err_short_w[0]),
`endif
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_data  (out_data[0])
   );

   wimax_deinterleaver #(.Ncbps(384), .Ncpc(4), .d(16)) dut_b (
      .clock_100 (clk),
      .reset     (reset),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
`ifdef DEINT_BLOCK_LAST_EN
      .in_last   (1'b0),
      .out_last  (out_last_w[1]),
      .err_short (err_short_w[1]),
`endif
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_data  (out_data[1])
   );

   // Every completed output handshake is recorded in arrival order.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++)
         if (reset === 1'b1 && out_valid[i] === 1'b1 && out_ready[i] === 1'b1 && capn[i] < 8192) begin
            cap[i][capn[i]] = out_data[i];
            capn[i] = capn[i] + 1;
         end
   end

   function automatic int ncb(input int inst);
      return (inst == 0) ? 192 : 384;
   endfunction

   function automatic int ncpcf(input int inst);
      return (inst == 0) ? 2 : 4;
   endfunction

   // Transmit-side 802.16 interleaver: original index k -> transmitted position.
   function automatic int intlv_pos(input int k, input int nc, input int ncpc);
      int s, mk;
      s  = (ncpc / 2 > 1) ? ncpc / 2 : 1;
      mk = (nc / D) * (k % D) + k / D;
      return s * (mk / s) + (mk + nc - (D * mk) / nc) % s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic build_tx(input int inst, input int nblk);
      int nc;
      nc = ncb(inst);
      for (int b = 0; b < nblk; b++)
         for (int k = 0; k < nc; k++)
            txbuf[b * nc + intlv_pos(k, nc, ncpcf(inst))] = orig[b * nc + k];
   endtask

   task automatic rand_orig(input int count);
      for (int i = 0; i < count; i++)
         orig[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 2'b11;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      capn[0] = 0;
      capn[1] = 0;
   endtask

   // Called just after a rising edge; returns just after the edge that accepts the last bit.
   task automatic send_stream(input int inst, input int start, input int cnt, input bit gaps);
      int idx, guard;
      idx   = 0;
      guard = 0;
      while (idx < cnt && guard < 20000) begin
         in_valid[inst] = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         in_data[inst]  = txbuf[start + idx];
         @(negedge clk);
         if (in_valid[inst] && in_ready[inst]) idx++;
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid[inst] = 1'b0;
      if (idx < cnt) check("send_timeout", idx, cnt);
   endtask

   task automatic wait_caps(input int inst, input int cnt, input string name);
      int guard;
      guard = 0;
      while (capn[inst] < cnt && guard < 20000) begin
         @(posedge clk);
         guard++;
      end
      #1;
      check(name, capn[inst], cnt);
   endtask

   task automatic compare_blocks(input int inst, input int nblk, input string name);
      int nc, errs;
      nc = ncb(inst);
      for (int b = 0; b < nblk; b++) begin
         errs = 0;
         for (int k = 0; k < nc; k++)
            if (cap[inst][b * nc + k] !== orig[b * nc + k]) errs++;
         check(name, errs, 0);
      end
   endtask

   task automatic rand_run(input int inst, input int nblk);
      int total;
      total = nblk * ncb(inst);
      do_reset();
      rand_orig(total);
      build_tx(inst, nblk);
      send_done = 1'b0;
      fork
         begin
            send_stream(inst, 0, total, 1'b1);
            send_done = 1'b1;
         end
         begin
            g = 0;
            while ((!send_done || capn[inst] < total) && g < 40000) begin
               @(posedge clk);
               #1;
               out_ready[inst] = 1'($urandom_range(0, 2) != 0);
               g++;
            end
            out_ready[inst] = 1'b1;
         end
      join
      wait_caps(inst, total, "rand_count");
      compare_blocks(inst, nblk, "rand_block");
   endtask

   initial begin
      tbl[0] = '{0, 12, 1};
      tbl[1] = '{0, 1, 16};
      tbl[2] = '{0, 191, 191};
      tbl[3] = '{0, 0, 0};
      tbl[4] = '{1, 24, 17};
      tbl[5] = '{1, 1, 16};
      tbl[6] = '{1, 383, 367};

      // Reset state
      reset     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = '0;
      capn[0]   = 0;
      capn[1]   = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 3);

      // One-hot blocks: received index j must land at output index exp_idx
      for (int t = 0; t < 7; t++) begin
         do_reset();
         n = ncb(tbl[t].inst);
         for (int i = 0; i < n; i++) txbuf[i] = 1'b0;
         txbuf[tbl[t].j] = 1'b1;
         send_stream(tbl[t].inst, 0, n, 1'b0);
         check("lat_before_first", 32'(out_valid[tbl[t].inst]), 0);
         @(posedge clk);
         #1;
         check("lat_first_valid", 32'(out_valid[tbl[t].inst]), 1);
         wait_caps(tbl[t].inst, n, "onehot_count");
         ones = 0;
         pos  = -1;
         for (int i = 0; i < n; i++)
            if (cap[tbl[t].inst][i] === 1'b1) begin
               ones++;
               pos = i;
            end
         check("onehot_ones", ones, 1);
         check("onehot_index", pos, tbl[t].exp_idx);
      end

      // Backpressure: both banks fill, then drain in order
      do_reset();
      out_ready[0] = 1'b0;
      rand_orig(384);
      build_tx(0, 2);
      send_stream(0, 0, 384, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("bp_in_ready_low", 32'(in_ready[0]), 0);
         check("bp_out_valid", 32'(out_valid[0]), 1);
         check("bp_out_hold", 32'(out_data[0]), 32'(orig[0]));
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      wait_caps(0, 384, "bp_drain_count");
      compare_blocks(0, 2, "bp_drain_data");
      @(posedge clk);
      #1;
      check("bp_in_ready_after", 32'(in_ready[0]), 1);

      // Randomised multi-block streams with gaps on both sides
      rand_run(0, 10);
      rand_run(1, 3);

      // Reset while block 1 drains and block 2 is part-written
      do_reset();
      out_ready[0] = 1'b0;
      rand_orig(384);
      build_tx(0, 2);
      send_stream(0, 0, 192, 1'b0);
      out_ready[0] = 1'b1;
      send_stream(0, 192, 100, 1'b0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 32'(out_valid[0]), 0);
      check("midrst_out_data", 32'(out_data[0]), 0);
      reset   = 1'b1;
      capn[0] = 0;
      @(posedge clk);
      #1;
      check("midrst_in_ready", 32'(in_ready[0]), 1);
      rand_orig(192);
      build_tx(0, 1);
      send_stream(0, 0, 192, 1'b0);
      wait_caps(0, 192, "post_rst_count");
      compare_blocks(0, 1, "post_rst_data");
      repeat (20) @(posedge clk);
      #1;
      check("post_rst_no_stale", capn[0], 192);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
